// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline stage register with a valid/ready handshake on both sides, a
// one-entry skid buffer and a synchronous flush. It carries a WIDTH-bit packed
// bundle of control/data fields from one pipeline stage to the next.
//
// The skid entry lets the downstream stage stall without a combinational
// ready path from out_ready back to in_ready. The hazard unit can squash the
// held contents into bubbles with flush.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge when valid and ready are both 1 in
//   the cycle before that edge. A producer holding valid=1 keeps its data stable
//   until the transfer completes. Ready may be asserted without valid.
//   in_ready is a function of registered state, flush and reset only.
//
// Parameters
//   WIDTH   bit width of the packed stage bundle
//   BUBBLE  value shown on out_data whenever the stage holds nothing
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset (same effect as flush)
//   flush      in   synchronous squash of every held entry
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage accepts in_data this cycle
//   in_data    in   upstream bundle
//   out_valid  out  out_data holds a live entry
//   out_ready  in   downstream consumes out_data this cycle
//   out_data   out  oldest held bundle, or BUBBLE when empty
//   occupancy  out  number of held entries, 0..2 (this is the FSM state)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // The encoding equals the number of held entries, so the state vector
    // doubles as the occupancy output.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;   // oldest entry, drives out_data
    logic [WIDTH-1:0] skid_q,  skid_d;   // second entry, only while FULL

    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    // in_ready is deliberately independent of out_ready: the skid entry
    // absorbs the one extra push that can arrive after a downstream stall.
    assign in_ready  = (state_q != ST_FULL) & ~flush & ~reset;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign push = in_valid  & in_ready;
    assign pop  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // A pop in this cycle still completes downstream. Only what
            // remains is discarded. in_ready is low, so nothing is pushed.
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end

                ST_ONE: begin
                    if (push && pop) begin
                        // The new entry replaces the departing one directly.
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end else if (push) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end

                ST_FULL: begin
                    // in_ready is low here, so the only event is a pop.
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers. Reset is the only source of initial values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
